router_fsm: RTL and testbench

- Control FSM for the 1xN packet router.
- Sequences the byte-wise packet flow from input through the router register stage into one of N output FIFOs.
- Decodes the header address, holds off when the destination FIFO is full or non-empty, and steers the register stage with per-state strobes.
- Sits between the input interface (pkt_valid/data_in) and the router register block; consumes that block's parity_done/low_pkt_valid.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_fsm.sv | 106 ++++++++++
 tb/tb_router_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1xN packet router: FSM, register stage and output FIFOs.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int ROUTER_ADDR_W    = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_fsm.sv
// Control FSM for the 1xN packet router: header decode, FIFO hold-off and register-stage strobes.
// Optional macro ROUTER_FSM_SOFT_RESET_EN adds soft_reset[] to abort a packet stuck on a timed-out FIFO.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = ROUTER_NUM_PORTS,
    parameter int ADDR_W    = ROUTER_ADDR_W
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
`ifdef ROUTER_FSM_SOFT_RESET_EN
    input  logic [NUM_PORTS-1:0] soft_reset,
`endif
    output logic [ADDR_W-1:0]    dest_sel,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy
);

    localparam int                ADDR_SPAN   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   NUM_PORTS_W = NUM_PORTS[ADDR_W:0];

    router_state_e          state_q, state_d;
    logic [ADDR_W-1:0]      dest_sel_q, dest_sel_d;
    logic [ADDR_SPAN-1:0]   empty_ext;
    logic                   addr_valid;

    // Pad the empty flags to the full address span so a variable index never leaves the vector.
    always_comb begin
        empty_ext                  = '0;
        empty_ext[NUM_PORTS-1:0]   = fifo_empty;
    end

    assign addr_valid = pkt_valid && ({1'b0, data_in} < NUM_PORTS_W);

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DECODE_ADDRESS;
            dest_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
        end
    end

    // NOTE: defaults first so every path assigns state_d/dest_sel_d and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (addr_valid) begin
                    dest_sel_d = data_in;
                    state_d    = empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[dest_sel_q]) state_d = LOAD_FIRST_DATA;
            end
            default:            state_d = DECODE_ADDRESS;
        endcase
`ifdef ROUTER_FSM_SOFT_RESET_EN
        if ((state_q != DECODE_ADDRESS) && soft_reset[dest_sel_q])
            state_d = DECODE_ADDRESS;
`endif
    end

    assign dest_sel      = dest_sel_q;
    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                        || (state_q == LOAD_AFTER_FULL);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios, then randomized cycles against a rule-level model.
module tb_router_fsm;

    localparam int NP = 3;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [AW-1:0] data_in;
    logic          fifo_full;
    logic [NP-1:0] fifo_empty;
    logic          parity_done;
    logic          low_pkt_valid;
`ifdef ROUTER_FSM_SOFT_RESET_EN
    logic [NP-1:0] soft_reset;
`endif
    logic [AW-1:0] dest_sel;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          rst_int_reg, write_enb_reg, busy;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
`ifdef ROUTER_FSM_SOFT_RESET_EN
        .soft_reset    (soft_reset),
`endif
        .dest_sel      (dest_sel),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Reference model: packet phases named by the rules, not by the RTL encoding.
    typedef enum {P_IDLE, P_FIRST, P_PAYLOAD, P_PARITY, P_STALLED, P_RESUME, P_WAIT, P_CHECK} phase_t;

    phase_t      ph;
    int unsigned dst;
    int          total    = 0;
    int          passed   = 0;
    int          we_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] expected_flags(input phase_t p);
        logic wr;
        logic bz;
        wr = (p == P_PAYLOAD) || (p == P_PARITY) || (p == P_RESUME);
        bz = !((p == P_IDLE) || (p == P_PAYLOAD));
        return {p == P_IDLE, p == P_FIRST, p == P_PAYLOAD, p == P_RESUME,
                p == P_STALLED, p == P_CHECK, wr, bz};
    endfunction

    function automatic logic [7:0] observed_flags();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_flags"}, {24'd0, observed_flags()}, {24'd0, expected_flags(ph)});
        chk({tag, "_dest"}, {30'd0, dest_sel}, dst);
    endtask

    // Apply current inputs for one clock; model and DUT both advance, then compare.
    task automatic tick(input string tag);
        phase_t      np;
        int unsigned nd;
        np = ph;
        nd = dst;
        case (ph)
            P_IDLE: begin
                if (pkt_valid && int'(data_in) < NP) begin
                    nd = data_in;
                    np = fifo_empty[data_in] ? P_FIRST : P_WAIT;
                end
            end
            P_FIRST:   np = P_PAYLOAD;
            P_PAYLOAD: np = fifo_full ? P_STALLED : (!pkt_valid ? P_PARITY : P_PAYLOAD);
            P_PARITY:  np = P_CHECK;
            P_CHECK:   np = fifo_full ? P_STALLED : P_IDLE;
            P_STALLED: np = fifo_full ? P_STALLED : P_RESUME;
            P_RESUME:  np = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_PAYLOAD);
            P_WAIT:    np = fifo_empty[dst] ? P_FIRST : P_WAIT;
            default:   np = P_IDLE;
        endcase
`ifdef ROUTER_FSM_SOFT_RESET_EN
        if (ph != P_IDLE && soft_reset[dst]) np = P_IDLE;
`endif
        @(posedge clock);
        #1;
        ph  = np;
        dst = nd;
        if (write_enb_reg) we_count++;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        pkt_valid     = 1'b0;
        data_in       = '0;
        fifo_full     = 1'b0;
        fifo_empty    = '1;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
`ifdef ROUTER_FSM_SOFT_RESET_EN
        soft_reset    = '0;
`endif
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        ph     = P_IDLE;
        dst    = 0;
        #12;
        check_outputs("reset");
        resetn = 1'b1;

        // Packet to port 1: header, 3 payload bytes, parity.
        pkt_valid = 1'b1; data_in = 2'd1; tick("p1_hdr");
        chk("p1_lfd", {31'd0, lfd_state}, 32'd1);
        we_count = 0;
        tick("p1_b1"); tick("p1_b2"); tick("p1_b3");
        pkt_valid = 1'b0; data_in = 2'd0;
        tick("p1_par"); tick("p1_lp"); tick("p1_cpe");
        chk("p1_writes", we_count, 32'd4);
        chk("p1_idle", {31'd0, detect_add}, 32'd1);

        // Port 2 not empty: wait five cycles, then drain.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
        tick("p2_hdr");
        pkt_valid = 1'b1; data_in = 2'd0;
        for (int i = 0; i < 4; i++) tick("p2_wait");
        chk("p2_busy", {31'd0, busy}, 32'd1);
        fifo_empty = 3'b111;
        tick("p2_go");
        tick("p2_b1");
        pkt_valid = 1'b0;
        tick("p2_par"); tick("p2_lp"); tick("p2_cpe");

        // Illegal address 3 is dropped; dest_sel keeps 2.
        pkt_valid = 1'b1; data_in = 2'd3;
        tick("bad_addr0"); tick("bad_addr1");
        chk("bad_dest", {30'd0, dest_sel}, 32'd2);
        chk("bad_we", {31'd0, write_enb_reg}, 32'd0);

        // Full during payload, pkt_valid falls while full, resume into parity.
        data_in = 2'd0; tick("f_hdr"); tick("f_lfd");
        fifo_full = 1'b1; tick("f_full0");
        pkt_valid = 1'b0; tick("f_full1"); tick("f_full2");
        chk("f_fullstate", {31'd0, full_state}, 32'd1);
        fifo_full = 1'b0; tick("f_laf");
        low_pkt_valid = 1'b1; tick("f_lp");
        low_pkt_valid = 1'b0; tick("f_cpe"); tick("f_idle");

        // Same, but the parity byte already captured: straight back to decode.
        pkt_valid = 1'b1; data_in = 2'd1; tick("g_hdr"); tick("g_lfd");
        fifo_full = 1'b1; tick("g_full");
        fifo_full = 1'b0; pkt_valid = 1'b0; tick("g_laf");
        parity_done = 1'b1; tick("g_done");
        parity_done = 1'b0;
        chk("g_idle", {31'd0, detect_add}, 32'd1);

        // Asynchronous reset in the middle of LOAD_DATA.
        pkt_valid = 1'b1; data_in = 2'd2; tick("r_hdr"); tick("r_lfd");
        #3 resetn = 1'b0;
        #1;
        ph  = P_IDLE;
        dst = 0;
        check_outputs("async_rst");
        #2 resetn = 1'b1;
        pkt_valid = 1'b0;
        tick("r_after");

`ifdef ROUTER_FSM_SOFT_RESET_EN
        // Soft reset on another port is ignored; on the active port it aborts the packet.
        pkt_valid = 1'b1; data_in = 2'd1; tick("s_hdr"); tick("s_lfd");
        soft_reset = 3'b001; tick("s_other");
        chk("s_other_ld", {31'd0, ld_state}, 32'd1);
        soft_reset = 3'b010; tick("s_hit");
        chk("s_hit_idle", {31'd0, detect_add}, 32'd1);
        soft_reset = '0; pkt_valid = 1'b0; tick("s_after");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = AW'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty    = NP'($urandom);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 1) == 0);
`ifdef ROUTER_FSM_SOFT_RESET_EN
            soft_reset    = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
`endif
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
